// File: rtl/cypher_scheduler_if.sv
// Requester-side bus of cypher_scheduler: per-requester job requests in,
// one-hot acks and a shared result strobe out.
interface cypher_scheduler_if #(
  parameter int NREQ = 4,
  parameter int MAXD = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [16*NREQ-1:0]     req_cypher;
  logic [4*MAXD*NREQ-1:0] req_digits;
  logic [4*NREQ-1:0]      req_len;
  logic [NREQ-1:0]        req_ack;
  logic                   done;
  logic [2:0]             done_id;
  logic                   done_right;
  logic [7:0]             done_sum;

  modport master (
    output req_valid, req_cypher, req_digits, req_len,
    input  req_ack, done, done_id, done_right, done_sum
  );

  modport slave (
    input  req_valid, req_cypher, req_digits, req_len,
    output req_ack, done, done_id, done_right, done_sum
  );
endinterface

// File: rtl/cypher_scheduler.sv
// Round-robin scheduler sharing one cypher_detector among NREQ requesters.
// Optional per-requester failure lockout is enabled with `define CYD_LOCKOUT_EN.
module cypher_scheduler #(
  parameter int NREQ       = 4,
  parameter int MAXD       = 8,
  parameter int LOCK_LIMIT = 3
) (
  input  logic             clock,
  input  logic             reset,
  cypher_scheduler_if.slave bus,
  output logic [15:0]      det_cypher,
  output logic [3:0]       det_num,
  output logic             det_read,
  output logic             det_clear,
  input  logic [7:0]       det_sum,
  input  logic             det_right,
  output logic             busy,
  output logic [NREQ-1:0]  lock_status
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] MAXD_L = 4'(MAXD);

  logic [2:0]          state_reg;
  logic [2:0]          rr_reg;
  logic [2:0]          id_reg;
  logic [15:0]         cypher_reg;
  logic [4*MAXD-1:0]   digits_reg;
  logic [3:0]          len_reg;
  logic [3:0]          k_reg;
  logic                right_reg;
  logic [7:0]          sum_reg;

  logic [NREQ-1:0]     eligible;
  logic                grant_found;
  logic [2:0]          grant_id;
  logic [15:0]         sel_cypher;
  logic [4*MAXD-1:0]   sel_digits;
  logic [3:0]          sel_len_raw;
  logic [3:0]          sel_len;
  logic [3:0]          cur_digit;
  logic                take;

  // First eligible index at or after the pointer, else the lowest eligible (wrap).
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && eligible[i] && (3'(i) >= rr_reg)) begin
        grant_found = 1'b1;
        grant_id    = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && eligible[i]) begin
        grant_found = 1'b1;
        grant_id    = 3'(i);
      end
    end
  end

  always_comb begin
    sel_cypher  = '0;
    sel_digits  = '0;
    sel_len_raw = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == 3'(i)) begin
        sel_cypher  = bus.req_cypher[16*i +: 16];
        sel_digits  = bus.req_digits[4*MAXD*i +: 4*MAXD];
        sel_len_raw = bus.req_len[4*i +: 4];
      end
    end
  end

  assign sel_len = (sel_len_raw > MAXD_L) ? MAXD_L : sel_len_raw;

  // Ack is masked by reset so every output reads 0 while reset is held.
  assign take = reset && (state_reg == S_IDLE) && grant_found;

  always_comb begin
    bus.req_ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ack[i] = take && (grant_id == 3'(i));
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int d = 0; d < MAXD; d++) begin
      if (k_reg == 4'(d)) cur_digit = digits_reg[4*d +: 4];
    end
  end

  assign busy           = (state_reg != S_IDLE);
  assign det_cypher     = busy ? cypher_reg : 16'd0;
  assign det_clear      = (state_reg == S_CLEAR);
  assign det_read       = (state_reg == S_FEED);
  assign det_num        = det_read ? cur_digit : 4'd0;
  assign bus.done       = (state_reg == S_DONE);
  assign bus.done_id    = bus.done ? id_reg : 3'd0;
  assign bus.done_right = bus.done && right_reg;
  assign bus.done_sum   = bus.done ? sum_reg : 8'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      rr_reg     <= '0;
      id_reg     <= '0;
      cypher_reg <= '0;
      digits_reg <= '0;
      len_reg    <= '0;
      k_reg      <= '0;
      right_reg  <= 1'b0;
      sum_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            state_reg  <= S_CLEAR;
            id_reg     <= grant_id;
            cypher_reg <= sel_cypher;
            digits_reg <= sel_digits;
            len_reg    <= sel_len;
            k_reg      <= '0;
            right_reg  <= 1'b0;
            sum_reg    <= '0;
            rr_reg     <= (grant_id == 3'(NREQ-1)) ? 3'd0 : grant_id + 3'd1;
          end
        end
        S_CLEAR: state_reg <= (len_reg == 4'd0) ? S_DONE : S_FEED;
        S_FEED:  state_reg <= S_CHECK;
        S_CHECK: begin
          right_reg <= det_right;
          sum_reg   <= det_sum;
          if (det_right || ((k_reg + 4'd1) == len_reg)) begin
            state_reg <= S_DONE;
          end else begin
            k_reg     <= k_reg + 4'd1;
            state_reg <= S_FEED;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef CYD_LOCKOUT_EN
  localparam int CW = $clog2(LOCK_LIMIT + 1);

  logic [NREQ-1:0] lock_vec;

  // A locked requester never finishes another job, so its counter stays saturated.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lock
    logic [CW-1:0] fail_cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        fail_cnt_reg <= '0;
      end else if ((state_reg == S_DONE) && (id_reg == 3'(gi))) begin
        if (right_reg) begin
          fail_cnt_reg <= '0;
        end else if (fail_cnt_reg != CW'(LOCK_LIMIT)) begin
          fail_cnt_reg <= fail_cnt_reg + 1'b1;
        end
      end
    end

    assign lock_vec[gi] = (fail_cnt_reg == CW'(LOCK_LIMIT));
  end

  assign lock_status = lock_vec;
  assign eligible    = bus.req_valid & ~lock_vec;
`else
  logic unused_lock_limit;

  assign unused_lock_limit = (LOCK_LIMIT > 0);
  assign lock_status       = '0;
  assign eligible          = bus.req_valid;
`endif

endmodule

// File: tb/tb_cypher_scheduler.sv
// Bench for cypher_scheduler: a small detector stand-in, a job-level reference
// model checked every cycle, and directed jobs with literal expectations.
module tb_cypher_scheduler;
  localparam int NREQ       = 4;
  localparam int MAXD       = 8;
  localparam int LOCK_LIMIT = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cypher_scheduler_if #(.NREQ(NREQ), .MAXD(MAXD)) bus ();

  logic [15:0]     det_cypher;
  logic [3:0]      det_num;
  logic            det_read;
  logic            det_clear;
  logic [7:0]      det_sum;
  logic            det_right;
  logic            busy;
  logic [NREQ-1:0] lock_status;

  cypher_scheduler #(.NREQ(NREQ), .MAXD(MAXD), .LOCK_LIMIT(LOCK_LIMIT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .det_cypher  (det_cypher),
    .det_num     (det_num),
    .det_read    (det_read),
    .det_clear   (det_clear),
    .det_sum     (det_sum),
    .det_right   (det_right),
    .busy        (busy),
    .lock_status (lock_status)
  );

  // Detector stand-in: running sum of digits, right when it equals the cypher's low byte.
  logic [7:0] det_nsum;
  assign det_nsum = det_sum + {4'd0, det_num};
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      det_sum   <= 8'd0;
      det_right <= 1'b0;
    end else if (det_clear) begin
      det_sum   <= 8'd0;
      det_right <= 1'b0;
    end else if (det_read) begin
      det_sum   <= det_nsum;
      det_right <= (det_nsum == det_cypher[7:0]);
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int model_winner(logic [NREQ-1:0] el, int rr);
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (rr + off) % NREQ;
      if (el[idx]) return idx;
    end
    return -1;
  endfunction

  // Job-level reference model and observation records.
  bit              job_active = 0;
  int              j_t, j_id, j_len, j_nreads, j_done_off;
  logic [15:0]     j_cy;
  logic [31:0]     j_digs;
  logic            j_right;
  logic [7:0]      j_sum;
  int              rr_m = 0;
  int              fails_m [NREQ];
  int              last_ack_cyc, last_done_cyc, last_reads, reads_seen;
  logic [2:0]      last_id;
  logic            last_right;
  logic [7:0]      last_sum;
  int              done_cnt = 0;
  int              m_off, m_k, m_w;
  logic            m_read;
  logic [NREQ-1:0] m_lock;

  initial begin
    for (int i = 0; i < NREQ; i++) fails_m[i] = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        job_active = 0;
        rr_m       = 0;
        for (int i = 0; i < NREQ; i++) fails_m[i] = 0;
      end else begin
        m_lock = '0;
`ifdef CYD_LOCKOUT_EN
        for (int i = 0; i < NREQ; i++) m_lock[i] = (fails_m[i] >= LOCK_LIMIT);
`endif
        chk("lock_status", lock_status, m_lock);
        if (bus.done) done_cnt++;
        if (!job_active) begin
          m_w = model_winner(bus.req_valid & ~m_lock, rr_m);
          chk("ack", bus.req_ack, (m_w >= 0) ? (64'd1 << m_w) : 64'd0);
          chk("busy_idle", busy, 0);
          chk("read_idle", det_read, 0);
          chk("clear_idle", det_clear, 0);
          chk("done_idle", bus.done, 0);
          chk("cypher_idle", det_cypher, 0);
          if (m_w >= 0) begin
            j_t    = cyc;
            j_id   = m_w;
            j_cy   = bus.req_cypher[16*m_w +: 16];
            j_digs = bus.req_digits[32*m_w +: 32];
            j_len  = int'(bus.req_len[4*m_w +: 4]);
            if (j_len > MAXD) j_len = MAXD;
            j_sum = 8'd0; j_right = 1'b0; j_nreads = 0;
            for (int kk = 0; kk < j_len && !j_right; kk++) begin
              j_sum = j_sum + 8'(j_digs[4*kk +: 4]);
              j_nreads++;
              if (j_sum == j_cy[7:0]) j_right = 1'b1;
            end
            j_done_off   = 2 + 2 * j_nreads;
            rr_m         = (m_w + 1) % NREQ;
            job_active   = 1;
            reads_seen   = 0;
            last_ack_cyc = cyc;
          end
        end else begin
          m_off  = cyc - j_t;
          m_k    = (m_off - 2) / 2;
          m_read = (m_off >= 2) && (m_off % 2 == 0) && (m_k < j_nreads);
          chk("busy_job", busy, 1);
          chk("ack_in_job", bus.req_ack, 0);
          chk("clear", det_clear, 64'(m_off == 1));
          chk("read", det_read, 64'(m_read));
          if (m_read) chk("num", det_num, j_digs[4*m_k +: 4]);
          chk("cypher", det_cypher, j_cy);
          chk("done", bus.done, 64'(m_off == j_done_off));
          if (det_read) reads_seen++;
          if (m_off == j_done_off) begin
            chk("done_id", bus.done_id, j_id);
            chk("done_right", bus.done_right, j_right);
            chk("done_sum", bus.done_sum, j_sum);
            last_done_cyc = cyc;
            last_id       = bus.done_id;
            last_right    = bus.done_right;
            last_sum      = bus.done_sum;
            last_reads    = reads_seen;
            if (j_right) fails_m[j_id] = 0;
            else if (fails_m[j_id] < LOCK_LIMIT) fails_m[j_id]++;
            job_active = 0;
          end
        end
      end
    end
  end

  task automatic set_req(int id, logic [15:0] cy, logic [3:0] len, logic [31:0] digs);
    bus.req_cypher[16*id +: 16] = cy;
    bus.req_len[4*id +: 4]      = len;
    bus.req_digits[32*id +: 32] = digs;
  endtask

  task automatic submit(int id, logic [15:0] cy, logic [3:0] len, logic [31:0] digs);
    bit got = 0;
    set_req(id, cy, len, digs);
    bus.req_valid[id] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clock);
      if (bus.req_ack[id]) got = 1;
    end
    chk("ack_wait", got, 1);
    @(posedge clock); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clock);
      if (bus.done) got = 1;
    end
    chk("done_wait", got, 1);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clock);
      if (!busy) got = 1;
    end
    chk("idle_wait", got, 1);
    @(posedge clock); #1;
  endtask

  int stream_log[$];

  task automatic stream(logic [NREQ-1:0] mask, int n);
    int cnt = 0;
    stream_log.delete();
    bus.req_valid = mask;
    for (int c = 0; c < 400 && cnt < n; c++) begin
      @(negedge clock);
      if (bus.req_ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) stream_log.push_back(i);
        cnt++;
      end
    end
    chk("stream_acks", cnt, n);
    @(posedge clock); #1;
    bus.req_valid = '0;
    wait_idle();
  endtask

  task automatic job(int id, logic [15:0] cy, logic [3:0] len, logic [31:0] digs);
    submit(id, cy, len, digs);
    wait_done();
    $display("job id=%0d len=%0d: done after %0d cycles, reads=%0d right=%0d sum=%0d",
             id, len, last_done_cyc - last_ack_cyc, last_reads, last_right, last_sum);
  endtask

  int saved_done;
  int n1;
  bit got_read;

  initial begin
    bus.req_valid  = '1;
    bus.req_cypher = '0;
    bus.req_digits = '0;
    bus.req_len    = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", bus.req_ack, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_clear", det_clear, 0);
    chk("rst_cypher", det_cypher, 0);
    chk("rst_lock", lock_status, 0);
    bus.req_valid = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Requester 2: digits 3,5,7 against low byte 8 -> match after digit 1.
    job(2, 16'hAB08, 4'd3, 32'h0000_0753);
    chk("t1_latency", last_done_cyc - last_ack_cyc, 6);
    chk("t1_reads", last_reads, 2);
    chk("t1_id", last_id, 2);
    chk("t1_right", last_right, 1);
    chk("t1_sum", last_sum, 8);

    // Requester 0: digits 1..4, no match.
    job(0, 16'h00FF, 4'd4, 32'h0000_4321);
    chk("t2_latency", last_done_cyc - last_ack_cyc, 10);
    chk("t2_reads", last_reads, 4);
    chk("t2_right", last_right, 0);
    chk("t2_sum", last_sum, 10);

    // Requester 1: zero-length job.
    job(1, 16'h1234, 4'd0, 32'h0000_0009);
    chk("t3_latency", last_done_cyc - last_ack_cyc, 2);
    chk("t3_reads", last_reads, 0);
    chk("t3_sum", last_sum, 0);

    // Requester 3: len 12 clamps to 8 digits.
    job(3, 16'h00FF, 4'd12, 32'h1111_1111);
    chk("t4_latency", last_done_cyc - last_ack_cyc, 18);
    chk("t4_reads", last_reads, 8);
    chk("t4_sum", last_sum, 8);

    // Fairness: all four valid, pointer is back at 0.
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h0105, 4'd1, 32'h5);
    stream(4'hF, 8);
    chk("fair_count", stream_log.size(), 8);
    for (int i = 0; i < stream_log.size(); i++) begin
      $display("fair grant %0d -> requester %0d", i, stream_log[i]);
      chk("fair_order", stream_log[i], i % 4);
    end

    // Abort a len=5 job in FEED with reset.
    submit(0, 16'h00FF, 4'd5, 32'h0001_1111);
    got_read = 0;
    for (int c = 0; c < 20 && !got_read; c++) begin
      @(negedge clock);
      if (det_read) got_read = 1;
    end
    chk("abort_feed_seen", got_read, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_read", det_read, 0);
    chk("abort_cypher", det_cypher, 0);
    chk("abort_done", bus.done, 0);
    saved_done = done_cnt;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    set_req(0, 16'h0105, 4'd1, 32'h5);
    set_req(2, 16'h0105, 4'd1, 32'h5);
    stream(4'b0101, 1);
    $display("after abort: first grant -> requester %0d", stream_log[0]);
    chk("abort_next_grant", stream_log[0], 0);
    chk("abort_done_count", done_cnt, saved_done + 1);

    // Requester 1 fails three times in a row, then competes with requester 2.
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    for (int r = 0; r < 3; r++) job(1, 16'h00FF, 4'd2, 32'h0000_0011);
`ifdef CYD_LOCKOUT_EN
    chk("lock_after_3", lock_status[1], 1);
`else
    chk("lock_after_3", lock_status[1], 0);
`endif
    set_req(2, 16'h0105, 4'd1, 32'h5);
    stream(4'b0110, 4);
    n1 = 0;
    foreach (stream_log[i]) if (stream_log[i] == 1) n1++;
    $display("lock phase: requester 1 granted %0d of 4", n1);
`ifdef CYD_LOCKOUT_EN
    chk("locked_grants", n1, 0);
`else
    chk("locked_grants", n1, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cypher_scheduler.md
Name: cypher_scheduler

Overview:
Round-robin scheduler that shares one cypher_detector instance between NREQ requesters. Each requester submits a 16-bit cypher and a short string of 4-bit digits. The scheduler clears the detector, feeds the digits one read pulse at a time, stops on the detector's right flag or after the last digit, and returns the verdict and sum to the owning requester. It sits between the requester bus and the detector's cypher/num/read/reset/sum/right pins.

Parameters:
NREQ, 4, number of requesters (2..8)
MAXD, 8, maximum digits per job (1..15)
LOCK_LIMIT, 3, consecutive failures before lockout (used only with the optional feature)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester job request; held with its data until req_ack
req_cypher  input  16*NREQ  cypher for requester i in bits [16i+15:16i]
req_digits  input  4*MAXD*NREQ  digits for requester i; digit k in bits [4*(MAXD*i+k)+3 : 4*(MAXD*i+k)]
req_len  input  4*NREQ  digit count for requester i (0..MAXD)
req_ack  output  NREQ  one-cycle one-hot pulse; job latched in this cycle
done  output  1  one-cycle result strobe
done_id  output  3  index of the finished requester
done_right  output  1  1 = detector raised right
done_sum  output  8  detector sum sampled at the last check
det_cypher  output  16  to detector cypher
det_num  output  4  to detector num
det_read  output  1  to detector read
det_clear  output  1  to detector reset, active-high one-cycle clear
det_sum  input  8  from detector sum
det_right  input  1  from detector right
busy  output  1  high whenever state != IDLE
lock_status  output  NREQ  lockout flags (optional feature; constant 0 when compiled out)

Behaviour:
- Reset (reset low, asynchronous): state IDLE, RR pointer 0, all outputs 0, latched job cleared.
- FSM states: IDLE, CLEAR, FEED, CHECK, DONE.
- IDLE: if any eligible req_valid is high, pick the first eligible index at or after the RR pointer (wrapping), pulse req_ack[winner], latch cypher/digits/len/id, set k=0, go to CLEAR. The RR pointer becomes winner+1 mod NREQ. With no eligible request, stay in IDLE.
- CLEAR: det_clear=1 for one cycle. If len==0, go to DONE with right=0, sum=0. Otherwise go to FEED.
- FEED: det_read=1, det_num=digit k; then go to CHECK.
- CHECK: det_read=0. Sample det_right and det_sum into result registers.
  - If det_right=1, go to DONE with right=1.
  - Else if k==len-1, go to DONE with right=0.
  - Else k=k+1 and go to FEED.
- DONE: done=1 with registered done_id, done_right, done_sum for exactly one cycle; then return to IDLE.
- det_cypher holds the latched cypher from CLEAR through DONE and is 0 in IDLE.
- Latency: ack at cycle t; FEED k at t+2+2k; done at t+4+2k_final. A full miss of L digits gives done at t+2+2L; len=0 gives done at t+2.
- req_len values greater than MAXD are clamped to MAXD.
- A request that drops valid before ack is simply not served.
- A new ack is never issued in the DONE cycle. Minimum spacing between acks is 3 cycles.
- Reset asserted mid-job aborts the job: no done pulse, and the job is not re-queued.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.

Optional Feature:
Macro CYD_LOCKOUT_EN.
- Defined: each requester has a saturating consecutive-failure counter. The counter increments on done with right=0 and clears on done with right=1. When it reaches LOCK_LIMIT, lock_status[i]=1 and requester i becomes ineligible for arbitration until reset. The failure that reaches the limit still reports done normally. Counters and flags clear on reset.
- Undefined: no counters, every requester is always eligible, lock_status is constant 0.

Test Plan:
- Single job, requester 2, len=3, detector model raises right after digit 1 -> ack[2] at t, read pulses at t+2 and t+4, done at t+6 with id=2, right=1, done_sum=model sum; no third read.
- Requester 0, len=4, no match -> 4 read pulses with digits in order, done at t+10 with right=0.
- len=0 -> det_clear pulse at t+1, no det_read, done at t+2 with right=0, sum=0.
- All 4 requesters held valid for 8 jobs -> ack order 0,1,2,3,0,1,2,3; no overlap between jobs.
- Assert reset low during FEED of a len=5 job -> outputs 0 immediately, no done pulse; after release, requester 0 wins the next grant.
- With CYD_LOCKOUT_EN and LOCK_LIMIT=3, requester 1 fails three times -> lock_status[1]=1 after the 3rd done; later valid requests from requester 1 are never acked while others are still served.
